// File: rtl/word_add_sequencer_pkg.sv
// Shared types and constants for the byte-serial word adder.
// Holds the controller state encoding and the slice width.
package word_add_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_add_sequencer_eightbit_adder.sv
// Combinational 8-bit ripple-carry adder slice (module eightbit_adder).
// Reused once per cycle by the word add sequencer.
module eightbit_adder
    import word_add_sequencer_pkg::*;
(
    input  logic [BYTE_W-1:0] in_1,
    input  logic [BYTE_W-1:0] in_2,
    input  logic              c_in,
    output logic [BYTE_W-1:0] sum,
    output logic              c_out
);

    logic cy;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        sum = '0;
        cy  = c_in;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i] = in_1[i] ^ in_2[i] ^ cy;
            cy     = (in_1[i] & in_2[i]) | (cy & (in_1[i] ^ in_2[i]));
        end
    end

    assign c_out = cy;

endmodule

// File: rtl/word_add_sequencer.sv
// Byte-serial NUM_BYTES*8-bit adder reusing one eightbit_adder, LSB first.
// Optional macro SUBTRACT_EN adds the sub input and ovf output (A-B mode).
module word_add_sequencer
    import word_add_sequencer_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BYTE_W*NUM_BYTES-1:0] op_a,
    input  logic [BYTE_W*NUM_BYTES-1:0] op_b,
    input  logic                        c_in,
`ifdef SUBTRACT_EN
    input  logic                        sub,
    output logic                        ovf,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [BYTE_W*NUM_BYTES-1:0] result,
    output logic                        c_out
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);

    state_t state, state_nx;

    logic [NUM_BYTES-1:0][BYTE_W-1:0] a_q;
    logic [NUM_BYTES-1:0][BYTE_W-1:0] b_q;
    logic [NUM_BYTES-1:0][BYTE_W-1:0] res_q;
    logic [IDX_W-1:0]                 idx;
    logic                             carry_q;
    logic                             accept;
    logic                             last_byte;
    logic [BYTE_W-1:0]                a_byte;
    logic [BYTE_W-1:0]                b_byte;
    logic [BYTE_W-1:0]                add_sum;
    logic                             add_co;

`ifdef SUBTRACT_EN
    logic sub_q;
    logic ovf_q;
`endif

    // A new operation can be taken whenever no bytes are in flight.
    assign accept    = start && (state != ADD);
    assign last_byte = (idx == LAST);

    assign a_byte = a_q[idx];
`ifdef SUBTRACT_EN
    assign b_byte = b_q[idx] ^ {BYTE_W{sub_q}};
`else
    assign b_byte = b_q[idx];
`endif

    eightbit_adder u_slice (
        .in_1  (a_byte),
        .in_2  (b_byte),
        .c_in  (carry_q),
        .sum   (add_sum),
        .c_out (add_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: run NUM_BYTES add cycles, then one done cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ADD;
            ADD:     if (last_byte) state_nx = DONE;
            DONE:    state_nx = start ? ADD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, per-byte result write-back and carry chaining.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q <= op_a;
            b_q <= op_b;
            idx <= '0;
`ifdef SUBTRACT_EN
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : c_in;
`else
            carry_q <= c_in;
`endif
        end else if (state == ADD) begin
            res_q[idx] <= add_sum;
            carry_q    <= add_co;
            if (!last_byte) idx <= idx + 1'b1;
`ifdef SUBTRACT_EN
            if (last_byte)
                ovf_q <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                         (add_sum[BYTE_W-1] != a_byte[BYTE_W-1]);
`endif
        end
    end

    assign busy   = (state == ADD);
    assign done   = (state == DONE);
    assign result = res_q;
    assign c_out  = carry_q;
`ifdef SUBTRACT_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_word_add_sequencer.sv
// Self-checking bench for word_add_sequencer: vector table, random ops
// against an arithmetic model, handshake and reset-mid-op sequences.
module tb_word_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
`ifdef SUBTRACT_EN
    logic         sub;
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    word_add_sequencer #(.NUM_BYTES(NB)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .c_in   (c_in),
`ifdef SUBTRACT_EN
        .sub    (sub),
        .ovf    (ovf),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] res;
        logic         co;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on whole words.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic s,
                         output logic [W-1:0] res, output logic co,
                         output logic ov);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            ur = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + longint'(ci);
            co = (ur >= (longint'(1) << W));
            sr = sa + sb + longint'(ci);
        end
        res = ur[W-1:0];
        ov  = (sr > ((longint'(1) << (W - 1)) - 1)) ||
              (sr < -(longint'(1) << (W - 1)));
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci,
                          input logic s, input logic [W-1:0] exp_res,
                          input logic exp_co, input logic exp_ov);
        int lat;
        int bcnt;
        logic [W-1:0] held;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        c_in  = ci;
        start = 1'b1;
`ifdef SUBTRACT_EN
        sub   = s;
`endif
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        c_in  = 1'($urandom);
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " latency"}, 64'(lat), 64'(NB + 1));
        chk({nm, " busy_cycles"}, 64'(bcnt), 64'(NB));
        chk({nm, " result"}, 64'(result), 64'(exp_res));
        chk({nm, " c_out"}, 64'(c_out), 64'(exp_co));
`ifdef SUBTRACT_EN
        chk({nm, " ovf"}, 64'(ovf), 64'(exp_ov));
`else
        if (s || exp_ov) $display("note: subtract/ovf not built");
`endif
        held = result;
        @(negedge clk);
        chk({nm, " done_pulse"}, 64'(done), 64'd0);
        chk({nm, " held"}, 64'(result), 64'(held));
    endtask

    vec_t tbl[5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] er, a0, b0, a1, b1, ra, rb;
        logic         ec, eo, rc, rs;
        int           d1, d2, seen;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        tbl[1] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        tbl[2] = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        c_in  = 1'b0;
`ifdef SUBTRACT_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset c_out", 64'(c_out), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            model(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0, er, ec, eo);
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci,
                   1'b0, tbl[i].res, tbl[i].co, eo);
        end

`ifdef SUBTRACT_EN
        run_op("sub 5-7", 32'd5, 32'd7, 1'b1, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub min-1", 32'h8000_0000, 32'd1, 1'b0, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
`ifdef SUBTRACT_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rc, rs, er, ec, eo);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, er, ec, eo);
        end

        // start held high, op_a churned every cycle
        @(negedge clk);
        a0 = $urandom;
        b0 = $urandom;
        a1 = '0;
        b1 = '0;
        op_a  = a0;
        op_b  = b0;
        c_in  = 1'b0;
        start = 1'b1;
`ifdef SUBTRACT_EN
        sub   = 1'b0;
`endif
        d1 = -1;
        d2 = -1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (done && d1 < 0) begin
                d1 = cyc;
                model(a0, b0, 1'b0, 1'b0, er, ec, eo);
                chk("hs first result", 64'(result), 64'(er));
                chk("hs first c_out", 64'(c_out), 64'(ec));
                a1   = $urandom;
                b1   = $urandom;
                op_a = a1;
                op_b = b1;
            end else if (done && d2 < 0) begin
                d2 = cyc;
                model(a1, b1, 1'b0, 1'b0, er, ec, eo);
                chk("hs second result", 64'(result), 64'(er));
                chk("hs second c_out", 64'(c_out), 64'(ec));
            end else begin
                op_a = $urandom;
            end
        end
        start = 1'b0;
        chk("hs first latency", 64'(d1), 64'(NB + 1));
        chk("hs spacing", 64'(d2 - d1), 64'(NB + 1));
        repeat (NB + 3) @(negedge clk);

        // reset during the second add cycle
        @(negedge clk);
        op_a  = 32'h0000_00AB;
        op_b  = 32'h0000_00AA;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst busy before", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst c_out", 64'(c_out), 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("rst no done", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
